booth_r4_digit_accumulator: RTL and testbench



---
 rtl/booth_r4_digit_accumulator.sv | 84 ++++++++
 tb/tb_booth_r4_digit_accumulator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/booth_r4_digit_accumulator.sv
// booth_r4_digit_accumulator: accumulates radix-4 Booth digits {neg,two,one} against a latched multiplicand
// Optional feature macro: BOOTH_R4_ILLEGAL_DIGIT_CHECK_EN (illegal digits 011/111 contribute 0 and set sticky err)
module booth_r4_digit_accumulator #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   multiplicand,
   input  logic           dig_valid,
   output logic           dig_ready,
   input  logic [2:0]     dig,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product,
   output logic           err
);
   localparam int D  = N / 2;
   localparam int IW = (D > 1) ? $clog2(D) : 1;
   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;
   state_t state, state_nxt;
   logic [N-1:0] a;
   logic [2*N-1:0] acc, ax, mag, pp, sum;
   logic [IW-1:0] idx;
   logic xfer, last, ill;
`ifdef BOOTH_R4_ILLEGAL_DIGIT_CHECK_EN
   assign ill = dig[0] & dig[1];
`else
   assign ill = 1'b0;
`endif
   assign xfer = dig_valid & dig_ready;
   assign last = idx == IW'(D - 1);
   assign ax   = {{N{a[N-1]}}, a};
   assign mag  = ill ? '0 : dig[1] ? (ax << 1) : dig[0] ? ax : '0;
   assign pp   = dig[2] ? -mag : mag;
   assign sum  = acc + (pp << {idx, 1'b0});
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else state <= state_nxt;
   end
   // next-state and handshake/status outputs
   always_comb begin
      state_nxt = state;
      dig_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = S_ACC;
         end
         S_ACC: begin
            dig_ready = 1'b1;
            if (dig_valid && last) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end
   // operand latch, weighted accumulation and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a       <= '0;
         acc     <= '0;
         idx     <= '0;
         product <= '0;
         err     <= 1'b0;
      end else if (state == S_IDLE && start) begin
         a   <= multiplicand;
         acc <= '0;
         idx <= '0;
         err <= 1'b0;
      end else if (xfer) begin
         acc <= sum;
         idx <= idx + 1'b1;
         err <= err | ill;
         if (last) product <= sum;
      end
   end
endmodule

// File: tb/tb_booth_r4_digit_accumulator.sv
// tb_booth_r4_digit_accumulator: randomized and directed checks against an arithmetic Booth product model
module tb_booth_r4_digit_accumulator;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  multiplicand = '0;
   logic        dig_valid = 1'b0;
   logic        dig_ready;
   logic [2:0]  dig = '0;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic        err;
   int checks = 0;
   int errors = 0;
   logic [15:0] last_p = '0;
   booth_r4_digit_accumulator #(.N(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .multiplicand(multiplicand),
      .dig_valid(dig_valid), .dig_ready(dig_ready), .dig(dig), .busy(busy),
      .done(done), .product(product), .err(err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   function automatic int dval(input logic [2:0] g);
      int m;
      m = g[1] ? 2 : g[0] ? 1 : 0;
`ifdef BOOTH_R4_ILLEGAL_DIGIT_CHECK_EN
      if (g[1] && g[0]) m = 0;
`endif
      return g[2] ? -m : m;
   endfunction
   function automatic logic [15:0] model(input logic [7:0] a, input logic [11:0] g);
      int s = 0;
      for (int i = 0; i < 4; i++) s += dval(g[3*i +: 3]) * (1 << (2 * i));
      return 16'(int'($signed(a)) * s);
   endfunction
   function automatic logic [11:0] enc(input logic [7:0] b);
      logic [8:0] x;
      logic [11:0] g;
      int v;
      x = {b, 1'b0};
      for (int i = 0; i < 4; i++) begin
         v = -2 * int'(x[2*i+2]) + int'(x[2*i+1]) + int'(x[2*i]);
         g[3*i +: 3] = v == 0 ? 3'b000 : v == 1 ? 3'b001 : v == 2 ? 3'b010 : v == -1 ? 3'b101 : 3'b110;
      end
      return g;
   endfunction
   task automatic run_op(input logic [7:0] a, input logic [11:0] g, input int stall_max,
                         input int stall_at, input bit hold_start, input logic [15:0] exp_p, input bit exp_e);
      int ns;
      start = 1'b1;
      multiplicand = a;
      @(posedge clk); #1;
      start = 1'b0;
      multiplicand = 8'($urandom);
      chk("ready_after_start", dig_ready, 1);
      chk("busy_acc", busy, 1);
      for (int i = 0; i < 4; i++) begin
         ns = (i == stall_at) ? 3 : $urandom_range(0, stall_max);
         repeat (ns) begin
            dig_valid = 1'b0;
            dig = 3'($urandom);
            start = 1'($urandom);
            @(posedge clk); #1;
            chk("stall_ready", dig_ready, 1);
            chk("stall_hold_product", product, last_p);
         end
         start = (i == 3) && hold_start;
         dig_valid = 1'b1;
         dig = g[3*i +: 3];
         @(posedge clk); #1;
         dig_valid = 1'b0;
         if (i < 3) begin
            chk("no_early_done", done, 0);
            chk("acc_hold_product", product, last_p);
         end
      end
      chk("done_pulse", done, 1);
      chk("product", product, exp_p);
      chk("err", err, exp_e);
      chk("done_not_ready", dig_ready, 0);
      chk("done_busy", busy, 1);
      last_p = exp_p;
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_single", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready", dig_ready, 0);
   endtask
   initial begin
      logic [7:0] a, b;
      logic [11:0] g;
      logic [15:0] ep;
      bit e;
      int k;
      #12;
      chk("rst_ready", dig_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_product", product, 0);
      chk("rst_err", err, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(8'd5, {3'b000, 3'b000, 3'b010, 3'b101}, 0, -1, 1'b0, 16'h0023, 1'b0);
      run_op(8'h80, {3'b110, 3'b000, 3'b000, 3'b000}, 0, -1, 1'b0, 16'h4000, 1'b0);
      run_op(8'd5, {3'b000, 3'b000, 3'b010, 3'b101}, 0, 1, 1'b1, 16'h0023, 1'b0);
      run_op(8'd5, {3'b000, 3'b000, 3'b001, 3'b100}, 0, -1, 1'b0, 16'h0014, 1'b0);
`ifdef BOOTH_R4_ILLEGAL_DIGIT_CHECK_EN
      run_op(8'd3, {3'b000, 3'b000, 3'b001, 3'b011}, 0, -1, 1'b0, 16'h000C, 1'b1);
`else
      run_op(8'd3, {3'b000, 3'b000, 3'b001, 3'b011}, 0, -1, 1'b0, 16'h0012, 1'b0);
`endif
      start = 1'b1;
      multiplicand = 8'd9;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         dig_valid = 1'b1;
         dig = 3'b001;
         @(posedge clk); #1;
      end
      dig_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", dig_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_product", product, 0);
      chk("midrst_err", err, 0);
      @(posedge clk); #1;
      chk("midrst_no_done", done, 0);
      rst_n = 1'b1;
      last_p = '0;
      @(posedge clk); #1;
      chk("midrst_idle_done", done, 0);
      run_op(8'd5, enc(8'd7), 0, -1, 1'b0, 16'h0023, 1'b0);
      for (int t = 0; t < 40; t++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         g = enc(b);
         ep = 16'(int'($signed(a)) * int'($signed(b)));
         e = 1'b0;
         for (int i = 0; i < 4; i++)
            if (g[3*i +: 3] == 3'b000 && $urandom_range(0, 1) == 1) g[3*i +: 3] = 3'b100;
         if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, 3);
            g[3*k +: 3] = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'b111;
            ep = model(a, g);
`ifdef BOOTH_R4_ILLEGAL_DIGIT_CHECK_EN
            e = 1'b1;
`endif
         end
         run_op(a, g, 2, -1, t[0], ep, e);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
